satd_block_ctrl: RTL and testbench

Parametrised sequencing controller for the SATD datapath. It replaces the free-running single-block controller with a start/done job interface, a configurable block height, a row valid/ready handshake toward the difference stage, and per-block result strobes aligned to the datapath pipeline latency. It sits between the pixel fetch unit (row source) and the diff → Hadamard → accumulate datapath.

---
 rtl/satd_pkg.sv | 25 ++
 rtl/satd_lat_pipe.sv | 34 +++
 rtl/satd_block_ctrl.sv | 141 ++++++++++++++
 tb/tb_satd_block_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/satd_pkg.sv
// Shared definitions for the SATD sequencing controller: FSM encoding,
// default block height and the row-index width helper.
package satd_pkg;

    localparam int SATD_ROWS_DEF = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_CLEAR = ST_CLEAR,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } satd_state_t;

    function automatic int row_idx_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/satd_lat_pipe.sv
// DEPTH-stage 1-bit delay line with synchronous clear; aligns the
// block-finished event with the accumulator output.
module satd_lat_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] pipe_reg;
    logic [DEPTH-1:0] pipe_next;

    assign pipe_next[0] = din;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_stage
            assign pipe_next[gi] = pipe_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    assign dout = pipe_reg[DEPTH-1];

endmodule

// File: rtl/satd_block_ctrl.sv
// Job sequencer for the diff -> Hadamard -> accumulate SATD datapath:
// start/done job interface, row handshake and latency-aligned result strobes.
module satd_block_ctrl
    import satd_pkg::*;
#(
    parameter int ROWS     = SATD_ROWS_DEF,
    parameter int NB_W     = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NB_W-1:0]             n_blocks,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        enable_diff,
    output logic                        reset_diff,
    output logic                        acc_clear,
    output logic [row_idx_w(ROWS)-1:0]  row_idx,
    output logic [NB_W-1:0]             blk_idx,
    output logic                        satd_valid,
    output logic                        busy,
    output logic                        done
);

    localparam int RW = row_idx_w(ROWS);
    localparam int DW = $clog2(PIPE_LAT + 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    satd_state_t     state_reg, state_next;
    logic [NB_W-1:0] nblk_reg,  nblk_next;
    logic [RW-1:0]   row_reg,   row_next;
    logic [NB_W-1:0] blk_reg,   blk_next;
    logic [DW-1:0]   drain_reg, drain_next;

    logic last_row;
    logic blk_last;
    logic blk_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            nblk_reg  <= '0;
            row_reg   <= '0;
            blk_reg   <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            nblk_reg  <= nblk_next;
            row_reg   <= row_next;
            blk_reg   <= blk_next;
            drain_reg <= drain_next;
        end
    end

    assign last_row = (row_reg == ROW_LAST);
    // Compared against the latched count so n_blocks = 2^NB_W-1 still terminates.
    assign blk_last = (blk_reg == nblk_reg - NB_W'(1));
    assign blk_done = (state_reg == S_RUN) & in_valid & last_row;

    always_comb begin
        state_next = state_reg;
        nblk_next  = nblk_reg;
        row_next   = row_reg;
        blk_next   = blk_reg;
        drain_next = drain_reg;
        in_ready   = 1'b0;
        reset_diff = 1'b0;
        acc_clear  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (n_blocks != '0) begin
                        nblk_next  = n_blocks;
                        state_next = S_CLEAR;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                reset_diff = 1'b1;
                acc_clear  = 1'b1;
                row_next   = '0;
                blk_next   = '0;
                state_next = S_RUN;
            end
            S_RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Block 0 was already cleared in CLEAR.
                    acc_clear = (row_reg == '0) && (blk_reg != '0);
                    if (last_row) begin
                        row_next = '0;
                        if (blk_last) begin
                            drain_next = '0;
                            state_next = S_DRAIN;
                        end else begin
                            blk_next = blk_reg + NB_W'(1);
                        end
                    end else begin
                        row_next = row_reg + RW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    state_next = S_DONE;
                end else begin
                    drain_next = drain_reg + DW'(1);
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign enable_diff = in_valid & in_ready;
    assign row_idx     = row_reg;
    assign blk_idx     = blk_reg;

    satd_lat_pipe #(
        .DEPTH(PIPE_LAT)
    ) u_lat_pipe (
        .clk (clk),
        .clr (rst),
        .din (blk_done),
        .dout(satd_valid)
    );

endmodule

// File: tb/tb_satd_block_ctrl.sv
// Randomized self-checking bench for satd_block_ctrl; expected behaviour is
// derived per job from accept counts and cycle offsets measured from start.
module tb_satd_block_ctrl;

    localparam int A_ROWS = 4;
    localparam int A_NBW  = 8;
    localparam int A_LAT  = 3;
    localparam int B_ROWS = 8;
    localparam int B_NBW  = 2;
    localparam int B_LAT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel      = 1'b0;
    logic       start    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] n_in     = 8'd0;

    logic       a_in_ready, a_enable_diff, a_reset_diff, a_acc_clear;
    logic       a_satd_valid, a_busy, a_done;
    logic [1:0] a_row_idx;
    logic [7:0] a_blk_idx;

    logic       b_in_ready, b_enable_diff, b_reset_diff, b_acc_clear;
    logic       b_satd_valid, b_busy, b_done;
    logic [2:0] b_row_idx;
    logic [1:0] b_blk_idx;

    satd_block_ctrl #(.ROWS(A_ROWS), .NB_W(A_NBW), .PIPE_LAT(A_LAT)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start & ~sel),
        .n_blocks   (n_in),
        .in_valid   (in_valid & ~sel),
        .in_ready   (a_in_ready),
        .enable_diff(a_enable_diff),
        .reset_diff (a_reset_diff),
        .acc_clear  (a_acc_clear),
        .row_idx    (a_row_idx),
        .blk_idx    (a_blk_idx),
        .satd_valid (a_satd_valid),
        .busy       (a_busy),
        .done       (a_done)
    );

    satd_block_ctrl #(.ROWS(B_ROWS), .NB_W(B_NBW), .PIPE_LAT(B_LAT)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start & sel),
        .n_blocks   (n_in[1:0]),
        .in_valid   (in_valid & sel),
        .in_ready   (b_in_ready),
        .enable_diff(b_enable_diff),
        .reset_diff (b_reset_diff),
        .acc_clear  (b_acc_clear),
        .row_idx    (b_row_idx),
        .blk_idx    (b_blk_idx),
        .satd_valid (b_satd_valid),
        .busy       (b_busy),
        .done       (b_done)
    );

    logic       o_in_ready, o_enable_diff, o_reset_diff, o_acc_clear;
    logic       o_satd_valid, o_busy, o_done;
    logic [7:0] o_row, o_blk;

    always_comb begin
        if (sel) begin
            o_in_ready    = b_in_ready;
            o_enable_diff = b_enable_diff;
            o_reset_diff  = b_reset_diff;
            o_acc_clear   = b_acc_clear;
            o_satd_valid  = b_satd_valid;
            o_busy        = b_busy;
            o_done        = b_done;
            o_row         = {5'd0, b_row_idx};
            o_blk         = {6'd0, b_blk_idx};
        end else begin
            o_in_ready    = a_in_ready;
            o_enable_diff = a_enable_diff;
            o_reset_diff  = a_reset_diff;
            o_acc_clear   = a_acc_clear;
            o_satd_valid  = a_satd_valid;
            o_busy        = a_busy;
            o_done        = a_done;
            o_row         = {6'd0, a_row_idx};
            o_blk         = a_blk_idx;
        end
    end

    int rows_cur = A_ROWS;
    int lat_cur  = A_LAT;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_in_ready"},    o_in_ready,    0);
        check_eq({tag, "_enable_diff"}, o_enable_diff, 0);
        check_eq({tag, "_reset_diff"},  o_reset_diff,  0);
        check_eq({tag, "_acc_clear"},   o_acc_clear,   0);
        check_eq({tag, "_satd_valid"},  o_satd_valid,  0);
        check_eq({tag, "_busy"},        o_busy,        0);
        check_eq({tag, "_done"},        o_done,        0);
        check_eq({tag, "_row_idx"},     o_row,         0);
        check_eq({tag, "_blk_idx"},     o_blk,         0);
    endtask

    // vmode: 0 random in_valid, 1 constant high, 2 toggling 1/0.
    // rst_at >= 0 aborts the job with a reset after that many accepts.
    // poke re-asserts start with a different count while the job runs.
    task automatic run_job(input int nb, input int vmode, input int rst_at, input bit poke);
        int  k, last, total, done_cyc, budget, n_strobe;
        int  strobes[$];
        bit  exp_run, exp_clear, acc, exp_sv, exp_done, finished;
        k        = 0;
        last     = -1;
        total    = nb * rows_cur;
        budget   = 40 + 4 * total + lat_cur;
        finished = 1'b0;
        n_strobe = 0;

        start    = 1'b1;
        n_in     = 8'(nb);
        in_valid = 1'($urandom);
        @(negedge clk);
        check_eq("idle_busy",   o_busy,        0);
        check_eq("idle_ready",  o_in_ready,    0);
        check_eq("idle_enable", o_enable_diff, 0);
        @(posedge clk); #1;

        for (int cyc = 1; cyc < budget && !finished; cyc++) begin
            if (rst_at >= 0 && k == rst_at) begin
                rst      = 1'b1;
                start    = 1'b0;
                in_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                for (int i = 0; i < 2 * lat_cur + 2; i++) begin
                    in_valid = 1'($urandom);
                    @(negedge clk);
                    check_quiet("after_rst");
                    @(posedge clk); #1;
                end
                $display("job n_blocks=%0d aborted by reset after %0d accepts", nb, k);
                return;
            end

            done_cyc  = (nb == 0) ? 1 : ((last >= 0) ? last + lat_cur + 1 : -1);
            exp_done  = (cyc == done_cyc);
            exp_clear = (nb != 0 && cyc == 1);
            exp_run   = (nb != 0 && cyc >= 2 && k < total);
            case (vmode)
                0:       in_valid = 1'($urandom);
                1:       in_valid = 1'b1;
                default: in_valid = ((cyc % 2) == 0);
            endcase
            start = exp_done || (poke && cyc == 3);
            n_in  = exp_done ? 8'd1 : 8'(nb + 1);
            acc   = exp_run && in_valid;
            exp_sv = (strobes.size() > 0 && strobes[0] == cyc);
            if (exp_sv) void'(strobes.pop_front());

            @(negedge clk);
            check_eq("in_ready",    o_in_ready,    exp_run);
            check_eq("busy",        o_busy,        1);
            check_eq("reset_diff",  o_reset_diff,  exp_clear);
            check_eq("done",        o_done,        exp_done);
            check_eq("enable_diff", o_enable_diff, acc);
            check_eq("acc_clear",   o_acc_clear,
                     exp_clear || (acc && (k % rows_cur) == 0 && k != 0));
            check_eq("satd_valid",  o_satd_valid,  exp_sv);
            if (acc) begin
                check_eq("row_idx", o_row, k % rows_cur);
                check_eq("blk_idx", o_blk, k / rows_cur);
                if ((k % rows_cur) == rows_cur - 1) strobes.push_back(cyc + lat_cur);
                if (k == total - 1) last = cyc;
                k++;
            end
            if (exp_sv) n_strobe++;
            finished = exp_done;
            @(posedge clk); #1;
        end

        check_eq("job_done_seen", finished, 1);
        check_eq("accepts",       k,        total);
        check_eq("strobes",       n_strobe, nb);

        start    = 1'b0;
        in_valid = 1'($urandom);
        @(negedge clk);
        check_eq("post_busy",  o_busy,       0);
        check_eq("post_ready", o_in_ready,   0);
        check_eq("post_sv",    o_satd_valid, 0);
        @(posedge clk); #1;
        $display("job rows=%0d n_blocks=%0d accepts=%0d strobes=%0d", rows_cur, nb, k, n_strobe);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        sel      = 1'b0;
        rows_cur = A_ROWS;
        lat_cur  = A_LAT;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("reset_a");
        @(posedge clk); #1;

        run_job(1, 1, -1, 1'b0);
        run_job(3, 2, -1, 1'b0);
        run_job(0, 0, -1, 1'b0);
        run_job(2, 1, 5, 1'b0);
        run_job(1, 1, -1, 1'b0);
        run_job(3, 0, -1, 1'b1);
        run_job(255, 1, -1, 1'b0);
        repeat (4) run_job(int'($urandom_range(1, 12)), 0, -1, 1'($urandom));

        sel      = 1'b1;
        rows_cur = B_ROWS;
        lat_cur  = B_LAT;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("reset_b");
        @(posedge clk); #1;

        run_job(3, 1, -1, 1'b0);
        run_job(3, 0, -1, 1'b1);
        run_job(0, 0, -1, 1'b0);
        run_job(1, 0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
